// File: rtl/port_req_issuer_pkg.sv
// Shared widths and reorder-buffer entry states for the port request issuer.
package port_req_issuer_pkg;

  localparam int unsigned ADDR_W    = 12;
  localparam int unsigned DATA_W    = 16;
  localparam int unsigned TAG_W     = 2;
  localparam int unsigned NUM_BANKS = 4;
  localparam int unsigned ROB_DEPTH = 4;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } rob_state_e;

endpackage

// File: rtl/port_rob.sv
// Reorder buffer: allocates read tags in order, captures bank responses out of order,
// and retires read data to the client in allocation order.
module port_rob
  import port_req_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           alloc,
  input  logic                           retire,
  input  logic [NUM_BANKS-1:0]           bank_valid,
  input  logic [NUM_BANKS*DATA_W-1:0]    bank_data,
  input  logic [NUM_BANKS*TAG_W-1:0]     bank_tag,
  output logic [TAG_W-1:0]               alloc_ptr,
  output logic                           can_alloc,
  output logic                           rsp_valid,
  output logic [DATA_W-1:0]              rsp_data,
  output logic [2:0]                     outstanding,
  output logic                           resp_err,
  output logic                           timeout
);

  localparam int unsigned AgeW = (TIMEOUT_CYCLES < 2) ? 2 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [AgeW-1:0] AgeMax     = '1;
  localparam logic [AgeW-1:0] TimeoutVal = AgeW'(TIMEOUT_CYCLES);

  rob_state_e        state_q [ROB_DEPTH];
  rob_state_e        state_d [ROB_DEPTH];
  logic [DATA_W-1:0] data_q  [ROB_DEPTH];
  logic [DATA_W-1:0] data_d  [ROB_DEPTH];
  logic [AgeW-1:0]   age_q   [ROB_DEPTH];
  logic [AgeW-1:0]   age_d   [ROB_DEPTH];
  logic [TAG_W-1:0]  alloc_ptr_q, alloc_ptr_d;
  logic [TAG_W-1:0]  retire_ptr_q, retire_ptr_d;
  logic [TAG_W-1:0]  tag;

  assign alloc_ptr = alloc_ptr_q;
  assign rsp_valid = (state_q[retire_ptr_q] == DONE);
  assign rsp_data  = data_q[retire_ptr_q];
  // When full, the entry retiring this cycle is the one alloc_ptr points at.
  assign can_alloc = (state_q[alloc_ptr_q] == FREE) || (retire && (alloc_ptr_q == retire_ptr_q));

  always_comb begin
    outstanding = 3'd0;
    for (int i = 0; i < ROB_DEPTH; i++) begin
      if (state_q[i] != FREE) outstanding = outstanding + 3'd1;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    resp_err     = 1'b0;
    timeout      = 1'b0;
    tag          = '0;
    alloc_ptr_d  = alloc_ptr_q;
    retire_ptr_d = retire_ptr_q;

    for (int i = 0; i < ROB_DEPTH; i++) begin
      age_d[i] = (age_q[i] == AgeMax) ? age_q[i] : age_q[i] + 1'b1;
      if (TIMEOUT_CYCLES != 0 && state_q[i] == WAIT && age_q[i] >= TimeoutVal) timeout = 1'b1;
    end

    // Checked against the running next state so a duplicate tag in one cycle is flagged.
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (bank_valid[b]) begin
        tag = bank_tag[b*TAG_W +: TAG_W];
        if (state_d[tag] == WAIT) begin
          state_d[tag] = DONE;
          data_d[tag]  = bank_data[b*DATA_W +: DATA_W];
        end else begin
          resp_err = 1'b1;
        end
      end
    end

    if (retire) begin
      state_d[retire_ptr_q] = FREE;
      retire_ptr_d          = retire_ptr_q + 1'b1;
    end

    if (alloc) begin
      state_d[alloc_ptr_q] = WAIT;
      age_d[alloc_ptr_q]   = '0;
      alloc_ptr_d          = alloc_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        state_q[i] <= FREE;
        data_q[i]  <= '0;
        age_q[i]   <= '0;
      end
      alloc_ptr_q  <= '0;
      retire_ptr_q <= '0;
    end else begin
      for (int i = 0; i < ROB_DEPTH; i++) begin
        state_q[i] <= state_d[i];
        data_q[i]  <= data_d[i];
        age_q[i]   <= age_d[i];
      end
      alloc_ptr_q  <= alloc_ptr_d;
      retire_ptr_q <= retire_ptr_d;
    end
  end

endmodule

// File: rtl/port_req_issuer.sv
// Issues client reads/writes to a banked memory port and returns read data in order
// through a 4-entry reorder buffer; keeps sticky protocol and timeout error flags.
module port_req_issuer
  import port_req_issuer_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 63
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        cl_req_valid,
  output logic                        cl_req_ready,
  input  logic [ADDR_W-1:0]           cl_addr,
  input  logic [DATA_W-1:0]           cl_wdata,
  input  logic                        cl_wen,
  output logic                        cl_rsp_valid,
  input  logic                        cl_rsp_ready,
  output logic [DATA_W-1:0]           cl_rsp_data,
  output logic [ADDR_W-1:0]           port_addr,
  output logic [DATA_W-1:0]           port_data_in,
  output logic                        port_wen,
  output logic [TAG_W-1:0]            port_req_tag_in,
  output logic                        port_valid,
  input  logic                        freeze_inputs,
  input  logic [NUM_BANKS-1:0]        bank_valid_out,
  input  logic [NUM_BANKS*DATA_W-1:0] bank_data_out,
  input  logic [NUM_BANKS*TAG_W-1:0]  bank_req_tag_out,
  output logic [2:0]                  outstanding,
  output logic [1:0]                  err_flags
);

  logic             accept;
  logic             deliver;
  logic             retire;
  logic             can_alloc;
  logic             resp_err;
  logic             timeout;
  logic [TAG_W-1:0] alloc_ptr;

  assign cl_req_ready = reset_n & (~port_valid | ~freeze_inputs) & (cl_wen | can_alloc);
  assign accept       = cl_req_valid & cl_req_ready;
  assign deliver      = port_valid & ~freeze_inputs;
  assign retire       = cl_rsp_valid & cl_rsp_ready;

  // A new request may overwrite the stage in the same cycle the old one delivers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      port_valid      <= 1'b0;
      port_addr       <= '0;
      port_data_in    <= '0;
      port_wen        <= 1'b0;
      port_req_tag_in <= '0;
    end else if (accept) begin
      port_valid      <= 1'b1;
      port_addr       <= cl_addr;
      port_data_in    <= cl_wdata;
      port_wen        <= cl_wen;
      port_req_tag_in <= alloc_ptr;
    end else if (deliver) begin
      port_valid      <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_flags <= 2'b00;
    end else begin
      err_flags <= err_flags | {timeout, resp_err};
    end
  end

  port_rob #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rob (
    .clk        (clk),
    .reset_n    (reset_n),
    .alloc      (accept & ~cl_wen),
    .retire     (retire),
    .bank_valid (bank_valid_out),
    .bank_data  (bank_data_out),
    .bank_tag   (bank_req_tag_out),
    .alloc_ptr  (alloc_ptr),
    .can_alloc  (can_alloc),
    .rsp_valid  (cl_rsp_valid),
    .rsp_data   (cl_rsp_data),
    .outstanding(outstanding),
    .resp_err   (resp_err),
    .timeout    (timeout)
  );

endmodule

// File: tb/tb_port_req_issuer.sv
// Scoreboard bench for port_req_issuer: expected deliveries and read data are queued at
// issue time and compared by independent monitors when the DUT presents them.
module tb_port_req_issuer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cl_req_valid;
  logic        cl_req_ready;
  logic [11:0] cl_addr;
  logic [15:0] cl_wdata;
  logic        cl_wen;
  logic        cl_rsp_valid;
  logic        cl_rsp_ready;
  logic [15:0] cl_rsp_data;
  logic [11:0] port_addr;
  logic [15:0] port_data_in;
  logic        port_wen;
  logic [1:0]  port_req_tag_in;
  logic        port_valid;
  logic        freeze_inputs;
  logic [3:0]  bank_valid_out;
  logic [63:0] bank_data_out;
  logic [7:0]  bank_req_tag_out;
  logic [2:0]  outstanding;
  logic [1:0]  err_flags;

  logic        t8_req_ready;
  logic        t8_rsp_valid;
  logic [15:0] t8_rsp_data;
  logic [11:0] t8_port_addr;
  logic [15:0] t8_port_data_in;
  logic        t8_port_wen;
  logic [1:0]  t8_port_tag;
  logic        t8_port_valid;
  logic [2:0]  t8_outstanding;
  logic [1:0]  t8_err_flags;

  int checks   = 0;
  int failures = 0;

  logic [30:0] dq[$];
  logic [15:0] rq[$];
  logic [30:0] exp_del;
  logic [15:0] exp_rsp;

  always #5 clk = ~clk;

  port_req_issuer dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .cl_req_valid    (cl_req_valid),
    .cl_req_ready    (cl_req_ready),
    .cl_addr         (cl_addr),
    .cl_wdata        (cl_wdata),
    .cl_wen          (cl_wen),
    .cl_rsp_valid    (cl_rsp_valid),
    .cl_rsp_ready    (cl_rsp_ready),
    .cl_rsp_data     (cl_rsp_data),
    .port_addr       (port_addr),
    .port_data_in    (port_data_in),
    .port_wen        (port_wen),
    .port_req_tag_in (port_req_tag_in),
    .port_valid      (port_valid),
    .freeze_inputs   (freeze_inputs),
    .bank_valid_out  (bank_valid_out),
    .bank_data_out   (bank_data_out),
    .bank_req_tag_out(bank_req_tag_out),
    .outstanding     (outstanding),
    .err_flags       (err_flags)
  );

  // Same stimulus, short timeout; only its error/occupancy outputs are inspected.
  port_req_issuer #(
    .TIMEOUT_CYCLES(8)
  ) dut_t8 (
    .clk             (clk),
    .reset_n         (reset_n),
    .cl_req_valid    (cl_req_valid),
    .cl_req_ready    (t8_req_ready),
    .cl_addr         (cl_addr),
    .cl_wdata        (cl_wdata),
    .cl_wen          (cl_wen),
    .cl_rsp_valid    (t8_rsp_valid),
    .cl_rsp_ready    (cl_rsp_ready),
    .cl_rsp_data     (t8_rsp_data),
    .port_addr       (t8_port_addr),
    .port_data_in    (t8_port_data_in),
    .port_wen        (t8_port_wen),
    .port_req_tag_in (t8_port_tag),
    .port_valid      (t8_port_valid),
    .freeze_inputs   (freeze_inputs),
    .bank_valid_out  (bank_valid_out),
    .bank_data_out   (bank_data_out),
    .bank_req_tag_out(bank_req_tag_out),
    .outstanding     (t8_outstanding),
    .err_flags       (t8_err_flags)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && port_valid === 1'b1 && freeze_inputs === 1'b0) begin
      if (dq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual=%0h required=none t=%0t", port_addr, $time);
      end else begin
        exp_del = dq.pop_front();
        chk("delivery", {port_addr, port_data_in, port_wen, port_req_tag_in}, exp_del);
      end
    end
  end

  always @(negedge clk) begin
    if (reset_n === 1'b1 && cl_rsp_valid === 1'b1 && cl_rsp_ready === 1'b1) begin
      if (rq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_rsp actual=%0h required=none t=%0t", cl_rsp_data, $time);
      end else begin
        exp_rsp = rq.pop_front();
        chk("rsp_data", cl_rsp_data, exp_rsp);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic issue(input logic [11:0] a, input logic [15:0] d, input logic w,
                       input logic [1:0] t, input logic [15:0] rd);
    int n = 0;
    cl_req_valid = 1'b1;
    cl_addr      = a;
    cl_wdata     = d;
    cl_wen       = w;
    do begin
      @(negedge clk);
      n++;
    end while (cl_req_ready !== 1'b1 && n < 64);
    if (cl_req_ready !== 1'b1) begin
      checks++;
      failures++;
      $display("FAIL issue_wait actual=not_ready required=ready addr=%0h", a);
      cl_req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    dq.push_back({a, d, w, t});
    if (!w) rq.push_back(rd);
    #1 cl_req_valid = 1'b0;
  endtask

  task automatic respond(input logic [3:0] v, input logic [7:0] tags, input logic [63:0] data);
    bank_valid_out   = v;
    bank_req_tag_out = tags;
    bank_data_out    = data;
    @(posedge clk);
    #1 bank_valid_out = 4'b0000;
  endtask

  task automatic do_reset(input bit drained);
    if (drained) begin
      chk("drain_delivery_q", dq.size(), 0);
      chk("drain_rsp_q", rq.size(), 0);
    end
    reset_n        = 1'b0;
    cl_req_valid   = 1'b0;
    cl_wen         = 1'b0;
    bank_valid_out = 4'b0000;
    freeze_inputs  = 1'b0;
    cl_rsp_ready   = 1'b1;
    @(negedge clk);
    chk("rst_port", {port_valid, port_wen, port_addr, port_data_in, port_req_tag_in}, 0);
    chk("rst_client", {cl_rsp_valid, cl_req_ready}, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_flags, 0);
    chk("rst_t8_err", t8_err_flags, 0);
    dq.delete();
    rq.delete();
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    reset_n          = 1'b0;
    cl_req_valid     = 1'b0;
    cl_addr          = '0;
    cl_wdata         = '0;
    cl_wen           = 1'b0;
    cl_rsp_ready     = 1'b1;
    freeze_inputs    = 1'b0;
    bank_valid_out   = '0;
    bank_data_out    = '0;
    bank_req_tag_out = '0;
    do_reset(1'b0);

    // Single read to bank 1, response 3 cycles after delivery.
    issue(12'h405, 16'h0000, 1'b0, 2'd0, 16'hBEEF);
    @(negedge clk);
    chk("t1_outstanding_1", outstanding, 1);
    @(posedge clk);
    #1;
    cycles(2);
    respond(4'b0010, 8'h00, 64'h0000_0000_BEEF_0000);
    @(negedge clk);
    chk("t1_rsp_data", {cl_rsp_valid, cl_rsp_data}, {1'b1, 16'hBEEF});
    cycles(1);
    @(negedge clk);
    chk("t1_outstanding_0", outstanding, 0);
    chk("t1_err", err_flags, 0);

    // Write held under freeze for 5 cycles.
    do_reset(1'b1);
    freeze_inputs = 1'b1;
    issue(12'h7A5, 16'h5A5A, 1'b1, 2'd0, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("frz_hold", {port_valid, port_addr, port_data_in, port_wen, port_req_tag_in},
          {1'b1, 12'h7A5, 16'h5A5A, 1'b1, 2'd0});
      chk("frz_ready", cl_req_ready, 0);
    end
    @(posedge clk);
    #1 freeze_inputs = 1'b0;
    cycles(1);
    @(negedge clk);
    chk("frz_cleared", port_valid, 0);
    chk("frz_outstanding", outstanding, 0);

    // Four reads answered in reverse order; write issues while full; 5th read stalls.
    do_reset(1'b1);
    issue(12'h000, 16'h0000, 1'b0, 2'd0, 16'h0000);
    issue(12'h400, 16'h0000, 1'b0, 2'd1, 16'h1111);
    issue(12'h800, 16'h0000, 1'b0, 2'd2, 16'h2222);
    issue(12'hC00, 16'h0000, 1'b0, 2'd3, 16'h3333);
    @(negedge clk);
    chk("ooo_full", outstanding, 4);
    @(posedge clk);
    #1;
    issue(12'h123, 16'hCAFE, 1'b1, 2'd0, 16'h0000);
    fork
      issue(12'h010, 16'h0000, 1'b0, 2'd0, 16'h5555);
      begin
        @(negedge clk);
        chk("ooo_stall", cl_req_ready, 0);
        @(posedge clk);
        #1;
        respond(4'b1000, 8'hC0, 64'h3333_0000_0000_0000);
        respond(4'b0100, 8'h20, 64'h0000_2222_0000_0000);
        respond(4'b0010, 8'h04, 64'h0000_0000_1111_0000);
        @(negedge clk);
        chk("ooo_still_stalled", {cl_req_ready, cl_rsp_valid}, 0);
        @(posedge clk);
        #1;
        respond(4'b0001, 8'h00, 64'h0000_0000_0000_0000);
      end
    join
    cycles(2);
    respond(4'b0001, 8'h00, 64'h0000_0000_0000_5555);
    cycles(6);
    @(negedge clk);
    chk("ooo_drained", outstanding, 0);
    chk("ooo_err", err_flags, 0);

    // All four banks respond in the same cycle with tags 3,2,1,0.
    do_reset(1'b1);
    cl_rsp_ready = 1'b0;
    issue(12'h001, 16'h0000, 1'b0, 2'd0, 16'hA000);
    issue(12'h402, 16'h0000, 1'b0, 2'd1, 16'hA001);
    issue(12'h803, 16'h0000, 1'b0, 2'd2, 16'hA002);
    issue(12'hC04, 16'h0000, 1'b0, 2'd3, 16'hA003);
    cycles(1);
    respond(4'b1111, 8'h1B, 64'hA000_A001_A002_A003);
    @(negedge clk);
    chk("par_outstanding", outstanding, 4);
    chk("par_head", {cl_rsp_valid, cl_rsp_data}, {1'b1, 16'hA000});
    @(posedge clk);
    #1 cl_rsp_ready = 1'b1;
    cycles(5);
    @(negedge clk);
    chk("par_drained", {cl_rsp_valid, outstanding}, 0);
    chk("par_err", err_flags, 0);

    // Response to a FREE entry.
    do_reset(1'b1);
    respond(4'b0100, 8'h20, 64'h0000_1234_0000_0000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_no_rsp", cl_rsp_valid, 0);
    end
    chk("stray_err", err_flags, 2'b01);

    // Reset discards an outstanding read; its late response is an error.
    do_reset(1'b0);
    issue(12'h001, 16'h0000, 1'b0, 2'd0, 16'h0BAD);
    cycles(2);
    do_reset(1'b0);
    respond(4'b0001, 8'h00, 64'h0000_0000_0000_DEAD);
    @(negedge clk);
    chk("late_err", err_flags, 2'b01);
    chk("late_state", {cl_rsp_valid, outstanding}, 0);

    // Unanswered read: timeout only on the 8-cycle instance.
    do_reset(1'b0);
    issue(12'h055, 16'h0000, 1'b0, 2'd0, 16'h0000);
    cycles(4);
    @(negedge clk);
    chk("to_early", t8_err_flags, 2'b00);
    cycles(8);
    @(negedge clk);
    chk("to_set", t8_err_flags, 2'b10);
    chk("to_still_wait", t8_outstanding, 1);
    chk("to_default_clear", err_flags, 2'b00);
    do_reset(1'b0);
    @(negedge clk);
    chk("post_reset_err", {err_flags, t8_err_flags, outstanding}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/port_req_issuer.md
PORT_REQ_ISSUER -- requirements
Module: port_req_issuer

Interface
REQ-001 TIMEOUT_CYCLES, 63, cycles a read may wait for its response before err_flags[1] sets; 0 disables the check.
REQ-002 clk  input  1  single clock, rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 cl_req_valid  input  1  client request valid.
REQ-005 cl_req_ready  output  1  request accepted at an edge where valid and ready are both 1.
REQ-006 cl_addr  input  12  word address; [11:10] is the bank ID.
REQ-007 cl_wdata  input  16  write data.
REQ-008 cl_wen  input  1  1 = write, 0 = read.
REQ-009 cl_rsp_valid  output  1  in-order read data available.
REQ-010 cl_rsp_ready  input  1  client consumes read data.
REQ-011 cl_rsp_data  output  16  read data.
REQ-012 port_addr  output  12  request address, broadcast to all banks.
REQ-013 port_data_in  output  16  request write data.
REQ-014 port_wen  output  1  request write enable.
REQ-015 port_req_tag_in  output  2  request tag.
REQ-016 port_valid  output  1  request valid.
REQ-017 freeze_inputs  input  1  OR of all banks' freeze_inputs; banks ignore the request while it is 1.
REQ-018 bank_valid_out  input  4  bit b = response valid from bank b for this port.
REQ-019 bank_data_out  input  64  data from bank b in [16b+15:16b].
REQ-020 bank_req_tag_out  input  8  tag from bank b in [2b+1:2b].
REQ-021 outstanding  output  3  number of ROB entries not FREE (0-4).
REQ-022 err_flags  output  2  sticky; [0] = response to a non-WAIT tag, [1] = timeout.

Function
REQ-023 Request stage SHALL be one register driving all port_* outputs; it SHALL hold them stable while port_valid=1 and freeze_inputs=1.
REQ-024 Delivery SHALL occur at an edge where port_valid=1 and freeze_inputs=0; port_valid SHALL clear on the next cycle unless a new request loads at that same edge.
REQ-025 cl_req_ready SHALL be (~port_valid | ~freeze_inputs) & (cl_wen | free ROB entry exists); this gives 1 request/cycle throughput when there is no freeze.
REQ-026 An accepted read SHALL take tag = alloc_ptr, move ROB[tag] FREE->WAIT, and increment alloc_ptr mod 4.
REQ-027 An accepted write SHALL carry tag = alloc_ptr, leave alloc_ptr unchanged, and allocate no entry; writes return no response.
REQ-028 Each cycle, for every bank b with bank_valid_out[b]=1, ROB[tag_b] SHALL go WAIT->DONE and capture data_b; up to 4 distinct tags in one cycle SHALL be accepted.
REQ-029 A response whose tag entry is not WAIT SHALL be dropped and SHALL set err_flags[0].
REQ-030 cl_rsp_valid SHALL equal (ROB[retire_ptr]==DONE), and cl_rsp_data SHALL be that entry's data (combinational).
REQ-031 On valid & ready, the entry SHALL go DONE->FREE and retire_ptr SHALL increment mod 4; the freed entry is reallocatable at the same edge.
REQ-032 When 4 entries are not FREE, reads SHALL stall and writes SHALL still issue.
REQ-033 Each entry SHALL have a saturating age counter, cleared on allocation; a WAIT entry whose age reaches TIMEOUT_CYCLES SHALL set err_flags[1] and remain WAIT.

Reset
REQ-034 While reset_n=0: port_* = 0, cl_rsp_valid = 0, cl_req_ready = 0, outstanding = 0, err_flags = 0, all ROB entries FREE, pointers and ages 0.
REQ-035 Reset mid-operation SHALL discard all outstanding reads; any late bank response after reset SHALL set err_flags[0].

Structure
REQ-036 Shared package SHALL hold ADDR_W=12, DATA_W=16, TAG_W=2, NUM_BANKS=4, ROB_DEPTH=4, and the entry-state enum {FREE, WAIT, DONE}.
REQ-037 The reorder buffer SHALL be the sub-module port_rob (entries, pointers, ages); the request stage and error logic SHALL be top-level.

Verification
REQ-038 Read 0x405 (tag 0), bank 1 returns tag 0 / 0xBEEF 3 cycles after delivery -> cl_rsp_data=0xBEEF, outstanding 1->0.
REQ-039 freeze_inputs=1 for 5 cycles with a write pending -> port_* stable for 5 cycles, delivered on the 6th, cl_req_ready=0 throughout.
REQ-040 Reads tags 0-3 to banks 0-3; responses return in order 3,2,1,0 with 0x3333/0x2222/0x1111/0x0000 -> client receives 0x0000, 0x1111, 0x2222, 0x3333 in order; 5th read stalls until first retire.
REQ-041 4 banks respond in one cycle with tags 0-3 -> all four entries DONE; delivered over 4 cycles with cl_rsp_ready=1.
REQ-042 Response with tag 2 while entry 2 is FREE -> err_flags=01; no cl_rsp_valid pulse.
REQ-043 TIMEOUT_CYCLES=8, read with no response -> err_flags[1]=1 at age 8; reset -> all outputs 0.
